// File: rtl/tcdm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tcdm_arb_pkg
//  Purpose : Shared helpers and constants for the TCDM round-robin arbiter.
//            - id_width() : bits needed to carry a master index (>= 1)
//            - TCDM_READ / TCDM_WRITE : encoding of the TCDM wen field
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package tcdm_arb_pkg;

  localparam logic TCDM_READ  = 1'b1;
  localparam logic TCDM_WRITE = 1'b0;

  // A single-master configuration still needs one ID bit to keep widths legal.
  function automatic int unsigned id_width(input int unsigned num_mst);
    return (num_mst > 1) ? $clog2(num_mst) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcdm_arb_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tcdm_arb_id_fifo
//  Purpose : In-order FIFO holding the master ID of every in-flight request.
//            Circular buffer with wrap-around read/write pointers, so DEPTH
//            need not be a power of two.
//  Ports   : clk_i, rst_ni (sync, active low)
//            push, data_in      : enqueue an ID (ignored when full)
//            pop                : dequeue head (ignored when empty)
//            head               : ID at the head of the queue
//            full, empty, count : occupancy status
//  Rev     : 1.0  initial release
// ============================================================================
module tcdm_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcdm_rr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tcdm_rr_port_arbiter
//  Purpose : Shares one TCDM slave port among NUM_MST masters with
//            round-robin arbitration. Granted master IDs are queued in order
//            and each slave response is routed back to the queue head.
//  Ports   : clk_i, rst_ni (sync, active low)
//            mst_*  : per-master TCDM request / grant / response
//            slv_*  : single TCDM port towards memory
//            outstanding_o : in-flight request count
//            err_o         : sticky, response arrived with no request pending
//  Rev     : 1.0  initial release
// ============================================================================
module tcdm_rr_port_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NUM_MST   = 4,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned ID_W  = id_width(NUM_MST),
  localparam int unsigned BE_W  = DATA_W / 8,
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_MST-1:0]             mst_req_i,
  output logic [NUM_MST-1:0]             mst_gnt_o,
  input  logic [NUM_MST-1:0][ADDR_W-1:0] mst_add_i,
  input  logic [NUM_MST-1:0]             mst_wen_i,
  input  logic [NUM_MST-1:0][BE_W-1:0]   mst_be_i,
  input  logic [NUM_MST-1:0][DATA_W-1:0] mst_data_i,
  output logic [NUM_MST-1:0][DATA_W-1:0] mst_r_data_o,
  output logic [NUM_MST-1:0]             mst_r_valid_o,
  output logic                           slv_req_o,
  input  logic                           slv_gnt_i,
  output logic [ADDR_W-1:0]              slv_add_o,
  output logic                           slv_wen_o,
  output logic [BE_W-1:0]                slv_be_o,
  output logic [DATA_W-1:0]              slv_data_o,
  input  logic [DATA_W-1:0]              slv_r_data_i,
  input  logic                           slv_r_valid_i,
  output logic [CNT_W-1:0]               outstanding_o,
  output logic                           err_o
);

  logic [ID_W-1:0]  r_ptr;
  logic             r_err;
  logic [ID_W-1:0]  w_sel;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_hs;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [ID_W-1:0]  w_head;
  logic [CNT_W-1:0] w_count;

  // Round-robin scan starting at r_ptr; first requester wins.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < NUM_MST; k++) begin
      w_idx = ID_W'((32'(r_ptr) + k) % NUM_MST);
      if (!w_any && mst_req_i[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
  end

  // Full blocks the request even if a pop lands this cycle, so r_valid never
  // reaches slv_req_o combinationally.
  assign slv_req_o = rst_ni & w_any & ~w_full;
  assign w_hs      = slv_req_o & slv_gnt_i;
  assign w_pop     = rst_ni & slv_r_valid_i & ~w_empty;

  always_comb begin
    mst_gnt_o  = '0;
    slv_add_o  = '0;
    slv_wen_o  = 1'b0;
    slv_be_o   = '0;
    slv_data_o = '0;
    if (w_hs) begin
      mst_gnt_o[w_sel] = 1'b1;
    end
    if (w_any) begin
      slv_add_o  = mst_add_i[w_sel];
      slv_wen_o  = mst_wen_i[w_sel];
      slv_be_o   = mst_be_i[w_sel];
      slv_data_o = mst_data_i[w_sel];
    end
  end

  always_comb begin
    mst_r_valid_o = '0;
    mst_r_data_o  = '0;
    if (w_pop) begin
      mst_r_valid_o[w_head] = 1'b1;
      mst_r_data_o[w_head]  = slv_r_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_ptr <= (w_sel == ID_W'(NUM_MST - 1)) ? '0 : w_sel + 1'b1;
      end
      if (slv_r_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (w_hs),
    .pop     (w_pop),
    .data_in (w_sel),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign outstanding_o = w_count;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tcdm_rr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tcdm_rr_port_arbiter
//  Purpose : Directed self-checking bench for tcdm_rr_port_arbiter with a
//            small in-order TCDM memory model (optionally withholding
//            responses).
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_tcdm_rr_port_arbiter;
  import tcdm_arb_pkg::*;

  logic             clk_i;
  logic             rst_ni;
  logic [3:0]       mst_req_i;
  logic [3:0]       mst_gnt_o;
  logic [3:0][31:0] mst_add_i;
  logic [3:0]       mst_wen_i;
  logic [3:0][3:0]  mst_be_i;
  logic [3:0][31:0] mst_data_i;
  logic [3:0][31:0] mst_r_data_o;
  logic [3:0]       mst_r_valid_o;
  logic             slv_req_o;
  logic             slv_gnt_i;
  logic [31:0]      slv_add_o;
  logic             slv_wen_o;
  logic [3:0]       slv_be_o;
  logic [31:0]      slv_data_o;
  logic [31:0]      slv_r_data_i;
  logic             slv_r_valid_i;
  logic [2:0]       outstanding_o;
  logic             err_o;

  tcdm_rr_port_arbiter #(
    .NUM_MST   (4),
    .MAX_OUTST (4),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mst_req_i     (mst_req_i),
    .mst_gnt_o     (mst_gnt_o),
    .mst_add_i     (mst_add_i),
    .mst_wen_i     (mst_wen_i),
    .mst_be_i      (mst_be_i),
    .mst_data_i    (mst_data_i),
    .mst_r_data_o  (mst_r_data_o),
    .mst_r_valid_o (mst_r_valid_o),
    .slv_req_o     (slv_req_o),
    .slv_gnt_i     (slv_gnt_i),
    .slv_add_o     (slv_add_o),
    .slv_wen_o     (slv_wen_o),
    .slv_be_o      (slv_be_o),
    .slv_data_o    (slv_data_o),
    .slv_r_data_i  (slv_r_data_i),
    .slv_r_valid_i (slv_r_valid_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_pass  = 0;
  int          n_total = 0;

  logic [31:0] mem [64];
  logic [31:0] rq [$];
  bit          auto_rsp;

  logic        cap_hs;
  logic        cap_rsp;
  logic [31:0] cap_add;
  logic        cap_wen;
  logic [3:0]  cap_be;
  logic [31:0] cap_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample the port mid-cycle, then update the memory model
  // just after the edge and drive the next response.
  task automatic step();
    logic [31:0] w;
    @(negedge clk_i);
    cap_hs   = slv_req_o & slv_gnt_i;
    cap_rsp  = slv_r_valid_i;
    cap_add  = slv_add_o;
    cap_wen  = slv_wen_o;
    cap_be   = slv_be_o;
    cap_data = slv_data_o;
    @(posedge clk_i);
    #1;
    if (cap_rsp && rq.size() > 0) void'(rq.pop_front());
    if (cap_hs) begin
      if (cap_wen == TCDM_READ) begin
        rq.push_back(mem[cap_add[7:2]]);
      end else begin
        w = mem[cap_add[7:2]];
        for (int b = 0; b < 4; b++) if (cap_be[b]) w[8*b +: 8] = cap_data[8*b +: 8];
        mem[cap_add[7:2]] = w;
        rq.push_back(32'h0);
      end
    end
    slv_r_valid_i = auto_rsp && (rq.size() > 0);
    slv_r_data_i  = (rq.size() > 0) ? rq[0] : 32'h0;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    mst_req_i     = '0;
    slv_r_valid_i = 1'b0;
    rq.delete();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; mst_req_i = '0; mst_add_i = '0; mst_wen_i = '0;
    mst_be_i = '0; mst_data_i = '0; slv_gnt_i = 1'b1;
    slv_r_data_i = '0; slv_r_valid_i = 1'b0; auto_rsp = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000 + i;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h12345678;

    do_reset();
    do_reset();
    #1;
    chk("rst_outst", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rvalid", mst_r_valid_o, 0);
    chk("rst_rdata", mst_r_data_o, 0);
    chk("rst_req", slv_req_o, 0);

    // Single read by master 2
    mst_req_i = 4'b0100; mst_add_i[2] = 32'h10; mst_wen_i[2] = TCDM_READ; mst_be_i[2] = 4'hF;
    #1;
    chk("t1_gnt", mst_gnt_o, 4'b0100);
    chk("t1_add", slv_add_o, 32'h10);
    chk("t1_outst0", outstanding_o, 0);
    step();
    mst_req_i = '0;
    #1;
    chk("t1_rvalid", mst_r_valid_o, 4'b0100);
    chk("t1_rdata", mst_r_data_o[2], 32'hDEADBEEF);
    chk("t1_rdata_other", mst_r_data_o[0], 0);
    chk("t1_outst1", outstanding_o, 1);
    step();
    #1;
    chk("t1_outst2", outstanding_o, 0);
    chk("t1_rvalid_end", mst_r_valid_o, 0);

    // Full contention, 1-cycle memory
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mst_add_i[i] = 32'(4 * i); mst_wen_i[i] = TCDM_READ; mst_be_i[i] = 4'hF;
    end
    mst_req_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t2_gnt", mst_gnt_o, 64'd1 << (c % 4));
      if (c > 0) begin
        chk("t2_rvalid", mst_r_valid_o, 64'd1 << ((c - 1) % 4));
        chk("t2_rdata", mst_r_data_o[(c - 1) % 4], 32'h1000 + (c - 1) % 4);
        chk("t2_outst", outstanding_o, 1);
      end
      step();
    end
    mst_req_i = '0;
    #1;
    chk("t2_last_rvalid", mst_r_valid_o, 4'b1000);
    chk("t2_last_rdata", mst_r_data_o[3], 32'h1003);
    step();

    // Outstanding limit with responses withheld
    do_reset();
    auto_rsp  = 1'b0;
    mst_req_i = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_req", slv_req_o, 1);
      chk("t3_gnt", mst_gnt_o, 64'd1 << c);
      chk("t3_outst", outstanding_o, c);
      step();
    end
    #1;
    chk("t3_full_req", slv_req_o, 0);
    chk("t3_full_gnt", mst_gnt_o, 0);
    chk("t3_full_outst", outstanding_o, 4);
    step();
    #1;
    chk("t3_hold_outst", outstanding_o, 4);
    slv_r_valid_i = 1'b1;
    slv_r_data_i  = rq[0];
    #1;
    chk("t3_pop_rvalid", mst_r_valid_o, 4'b0001);
    chk("t3_pop_rdata", mst_r_data_o[0], 32'h1000);
    chk("t3_pop_req", slv_req_o, 0);
    step();
    #1;
    chk("t3_after_outst", outstanding_o, 3);
    chk("t3_after_req", slv_req_o, 1);
    chk("t3_after_gnt", mst_gnt_o, 4'b0001);

    // Partial write, then read back by another master
    auto_rsp = 1'b1;
    do_reset();
    mst_req_i = 4'b0010; mst_add_i[1] = 32'h20; mst_wen_i[1] = TCDM_WRITE;
    mst_be_i[1] = 4'b0011; mst_data_i[1] = 32'hA5A5A5A5;
    #1;
    chk("t4_wgnt", mst_gnt_o, 4'b0010);
    chk("t4_wen", slv_wen_o, TCDM_WRITE);
    chk("t4_be", slv_be_o, 4'b0011);
    chk("t4_wdata", slv_data_o, 32'hA5A5A5A5);
    step();
    mst_req_i = 4'b1000; mst_add_i[3] = 32'h20; mst_wen_i[3] = TCDM_READ; mst_be_i[3] = 4'hF;
    #1;
    chk("t4_wrsp", mst_r_valid_o, 4'b0010);
    chk("t4_rgnt", mst_gnt_o, 4'b1000);
    step();
    mst_req_i = '0;
    #1;
    chk("t4_rrsp", mst_r_valid_o, 4'b1000);
    chk("t4_rdata", mst_r_data_o[3], 32'h1234A5A5);
    step();

    // Response with nothing outstanding
    #1;
    chk("t5_err_pre", err_o, 0);
    slv_r_valid_i = 1'b1;
    slv_r_data_i  = 32'hBAD;
    #1;
    chk("t5_rvalid", mst_r_valid_o, 0);
    step();
    #1;
    chk("t5_err", err_o, 1);
    chk("t5_outst", outstanding_o, 0);
    step();
    #1;
    chk("t5_err_sticky", err_o, 1);
    do_reset();
    #1;
    chk("t5_err_clr", err_o, 0);

    // Reset with requests in flight
    auto_rsp  = 1'b0;
    mst_req_i = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_gnt", mst_gnt_o, 64'd1 << c);
      step();
    end
    #1;
    chk("t6_outst3", outstanding_o, 3);
    do_reset();
    #1;
    chk("t6_outst0", outstanding_o, 0);
    mst_req_i = 4'b1111;
    #1;
    chk("t6_first_gnt", mst_gnt_o, 4'b0001);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tcdm_rr_port_arbiter.md
Name: tcdm_rr_port_arbiter

Overview:
Shares one 32-bit TCDM slave port, such as a testbench TCDM memory port, between NUM_MST requesters. Arbitration is round-robin.
Each accepted request pushes the granted master's ID into an in-order ID FIFO. Each slave response pops that FIFO and is routed back to the originating master.
The block sits between the engine's streamer TCDM ports and a memory port, so several masters can share fewer memory ports.

Parameters:
NUM_MST, 4, number of requesting masters (2..16)
MAX_OUTST, 4, maximum in-flight requests (ID FIFO depth; 1..16; power of two not required)
ADDR_W, 32, address width
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
mst_req_i  in  NUM_MST  per-master request
mst_gnt_o  out  NUM_MST  per-master grant (combinational)
mst_add_i  in  NUM_MST x ADDR_W  byte address
mst_wen_i  in  NUM_MST  1 = read, 0 = write
mst_be_i  in  NUM_MST x DATA_W/8  byte enables
mst_data_i  in  NUM_MST x DATA_W  write data
mst_r_data_o  out  NUM_MST x DATA_W  response data
mst_r_valid_o  out  NUM_MST  response valid, one-hot or zero
slv_req_o  out  1  request to memory
slv_gnt_i  in  1  grant from memory
slv_add_o / slv_wen_o / slv_be_o / slv_data_o  out  ADDR_W / 1 / DATA_W/8 / DATA_W  forwarded request fields
slv_r_data_i  in  DATA_W  memory response data
slv_r_valid_i  in  1  memory response valid (in order; read and write both respond)
outstanding_o  out  $clog2(MAX_OUTST+1)  in-flight count
err_o  out  1  sticky: response received with ID FIFO empty

Behaviour:
- Reset (synchronous, rst_ni = 0 at a clk_i edge):
  - RR pointer = 0; ID FIFO empty; outstanding_o = 0; err_o = 0.
  - All mst_gnt_o, mst_r_valid_o, slv_req_o = 0.
  - mst_r_data_o = 0.
- Selection (combinational):
  - sel = first i with mst_req_i[i] = 1, scanning ptr, ptr+1, … mod NUM_MST.
  - slv_req_o = |mst_req_i & ~fifo_full.
  - Slave request fields are muxed from master sel.
  - When no master requests, fields are 0.
- Grant: mst_gnt_o[sel] = slv_req_o & slv_gnt_i; all other grants are 0. At most one grant per cycle.
- On a handshake (slv_req_o & slv_gnt_i), at the clock edge:
  - push sel into the ID FIFO;
  - ptr <= (sel+1) mod NUM_MST.
- With no handshake, ptr holds. A master that keeps req high is served once per NUM_MST handshakes under full contention.
- Full condition: fifo_full (count == MAX_OUTST) blocks slv_req_o even if slv_r_valid_i pops in the same cycle. This keeps the path from r_valid to req non-combinational.
- Response path:
  - When slv_r_valid_i = 1 and the FIFO is non-empty:
    - mst_r_valid_o[head] = 1 in the same cycle (combinational);
    - mst_r_data_o[head] = slv_r_data_i;
    - the head is popped at the edge.
  - Non-selected masters see r_valid = 0 and r_data = 0.
- Simultaneous push and pop: both happen; count is unchanged.
- Empty-pop: slv_r_valid_i = 1 with the FIFO empty is dropped. err_o <= 1 and stays set until reset; FIFO and count are unaffected.
- Reset mid-operation: in-flight IDs are discarded. Responses arriving after reset hit the empty-pop rule. The memory must be reset together with the arbiter.
- Master-side rule: a master holds req and its fields stable until it sees gnt (TCDM protocol). The arbiter does not check this.
- Latency: zero added cycles on both the request and response paths. With a memory that returns r_valid the cycle after gnt, throughput is 1 request per cycle.

Decomposition:
- Package tcdm_arb_pkg holds:
  - function id_width(NUM_MST) = max(1, $clog2(NUM_MST));
  - constants TCDM_READ = 1'b1 and TCDM_WRITE = 1'b0.
- Sub-module tcdm_arb_id_fifo:
  - parameters DEPTH and WIDTH;
  - ports push, pop, data_in, head, full, empty, count;
  - synchronous active-low reset;
  - circular buffer with wrap-around read and write pointers.
- The top level contains the RR pointer, the priority mux, response demux and err flag.

Test Plan:
1. Reset, then only master 2 reads addr 0x10 with memory word 0xDEADBEEF, slv_gnt_i = 1 → mst_gnt_o = 4'b0100. Next cycle mst_r_valid_o = 4'b0100 and mst_r_data_o[2] = 0xDEADBEEF. outstanding_o goes 0→1→0.
2. All 4 masters request continuously for 8 cycles, 1-cycle memory → grant order 0,1,2,3,0,1,2,3. Each response is routed to the master granted the previous cycle.
3. slv_gnt_i tied 1, memory withholds r_valid → exactly MAX_OUTST = 4 handshakes. slv_req_o then drops to 0 and outstanding_o = 4. Releasing one response → outstanding_o = 3 and req reasserts the next cycle.
4. Master 1 writes 0xA5A5A5A5 to 0x20 with be = 4'b0011 over old word 0x12345678. Master 3 then reads 0x20 → master 3 receives 0x1234A5A5. Write r_valid goes to master 1 only.
5. slv_r_valid_i pulsed with the FIFO empty → err_o = 1 on the next cycle and stays 1. All mst_r_valid_o = 0, outstanding_o = 0. Reset clears err_o.
6. rst_ni asserted for 1 cycle with 3 requests in flight → outstanding_o = 0 and ptr = 0 afterwards. The first post-reset contention grants master 0.
